// File: rtl/spart_tx_framer.sv
// rtl/spart_tx_framer.sv - SPART transmit framer: NUM_BYTES 8N1 characters per send_tx strobe
// Optional even parity bit per character when SPART_TX_PARITY_EN is defined.
module spart_tx_framer #(
    parameter int BAUD_DIV  = 434,
    parameter int NUM_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send_tx,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    output logic                   txd,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   tx_drop
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(NUM_BYTES) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

    state_t                 state, state_nxt;
    logic [8*NUM_BYTES-1:0] shreg;
    logic [CW-1:0]          baud_cnt;
    logic [2:0]             bit_idx;
    logic [BW-1:0]          byte_idx;
    logic                   baud_end;
    logic                   accept;
`ifdef SPART_TX_PARITY_EN
    logic                   par;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        txd       = 1'b1;
        busy      = 1'b0;
        tx_done   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                tx_done = (state == S_DONE);
                // DONE doubles as an idle cycle so frames can run back to back
                if (send_tx) begin
                    state_nxt = S_START;
                    accept    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                busy = 1'b1;
                txd  = 1'b0;
                if (baud_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                busy = 1'b1;
                txd  = shreg[0];
                if (baud_end && bit_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef SPART_TX_PARITY_EN
            S_PARITY: begin
                busy = 1'b1;
                txd  = par;
                if (baud_end) state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                busy = 1'b1;
                if (baud_end) state_nxt = (byte_idx < BYTE_LAST) ? S_START : S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign tx_drop = send_tx && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
`ifdef SPART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (accept) begin
            shreg    <= tx_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
`ifdef SPART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (busy) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            if (baud_end && state == S_DATA) begin
                // shifting out LSB-first leaves the next byte at [7:0] after 8 bits
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
`ifdef SPART_TX_PARITY_EN
                par     <= par ^ shreg[0];
`endif
            end
            if (baud_end && state == S_STOP) begin
                byte_idx <= byte_idx + 1'b1;
`ifdef SPART_TX_PARITY_EN
                par      <= 1'b0;
`endif
            end
        end
    end

endmodule
